factor_quiz_top: RTL and testbench

- Top-level of a prime-factorization quiz game for a board with six active-low 7-segment digits, slide switches, push-buttons and one LED.
- Loads a composite number from an internal ROM and shows it in decimal.
- The player latches a prime with SEL and applies it with DEC. A correct divisor divides the number; a wrong one costs a life.
- LEDR lights when the number reaches 1.

---
 rtl/factor_quiz_pkg.sv | 45 ++++
 rtl/factor_quiz_seg7_dec.sv | 18 +
 rtl/factor_quiz_top.sv | 177 +++++++++++++++++
 tb/tb_factor_quiz_top.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/factor_quiz_pkg.sv
// Shared types and constants for the factor quiz: FSM states, prime and question tables, 7-seg glyphs.
// No logic state; pure constants and a combinational binary-to-BCD helper.
// Backpressure: not applicable.
package factor_quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_SOLVED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam int ROM_DEPTH = 8;

    // Index 0 is the first question served after reset.
    localparam logic [ROM_DEPTH-1:0][9:0] QUESTION_ROM = {
        10'd884, 10'd462, 10'd360, 10'd210, 10'd90, 10'd84, 10'd30, 10'd12
    };

    localparam logic [7:0][4:0] PRIME_LUT = {
        5'd17, 5'd13, 5'd11, 5'd7, 5'd5, 5'd3, 5'd2, 5'd0
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low, bit0 = segment a .. bit6 = segment g.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
        logic [21:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 10; i++) begin
            if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
            if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
            if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
            sh = sh << 1;
        end
        return sh[21:10];
    endfunction

endpackage

// File: rtl/factor_quiz_seg7_dec.sv
// One decimal digit to active-low 7-segment pattern, with a blank override.
// Latency: combinational. Backpressure: not applicable.
module seg7_dec
    import factor_quiz_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && digit_i <= 4'd9) begin
            seg_o = SEG_DIGIT[digit_i];
        end
    end

endmodule

// File: rtl/factor_quiz_top.sv
// Prime-factorization quiz: ROM question, prime latch/apply, lives, six-digit display, solved LED.
// Latency: 1 cycle edge-to-display (3 with INPUT_SYNC_EN defined). Backpressure: none, inputs are levels/edges.
module factor_quiz_top
    import factor_quiz_pkg::*;
#(
    parameter int NUM_Q = 8,
    parameter int NUM_W = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] HP,
    input  logic [2:0] SEL,
    input  logic       DEC,
    input  logic       CLR,
    input  logic       READY,
    input  logic       QUE,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       LEDR
);

    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    logic       dec_s, clr_s, que_s, ready_s;
    logic [2:0] sel_s;

`ifdef INPUT_SYNC_EN
    logic [6:0] sync1_q, sync2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {SEL, READY, QUE, CLR, DEC};
            sync2_q <= sync1_q;
        end
    end

    assign {sel_s, ready_s, que_s, clr_s, dec_s} = sync2_q;
`else
    assign {sel_s, ready_s, que_s, clr_s, dec_s} = {SEL, READY, QUE, CLR, DEC};
`endif

    logic dec_prev_q, clr_prev_q, que_prev_q;
    logic dec_edge, clr_edge, que_edge;

    assign dec_edge = dec_s & ~dec_prev_q;
    assign clr_edge = clr_s & ~clr_prev_q;
    assign que_edge = que_s & ~que_prev_q;

    state_t           state_q, state_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [2:0]       lives_q, lives_d;
    logic [2:0]       psel_q, psel_d;
    logic [QW-1:0]    qidx_q, qidx_d;
    logic [5:0][6:0]  hex_q, hex_d;

    logic [NUM_W-1:0] quo, rem;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            lives_q    <= '0;
            psel_q     <= '0;
            qidx_q     <= '0;
            hex_q      <= {6{SEG_BLANK}};
            dec_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
            que_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            lives_q    <= lives_d;
            psel_q     <= psel_d;
            qidx_q     <= qidx_d;
            hex_q      <= hex_d;
            dec_prev_q <= dec_s;
            clr_prev_q <= clr_s;
            que_prev_q <= que_s;
        end
    end

    // Constant divisors per prime keep the divider to a handful of fixed-ratio circuits.
    always_comb begin
        quo = num_q;
        rem = '0;
        case (psel_q)
            3'd1: begin quo = num_q / NUM_W'(2);  rem = num_q % NUM_W'(2);  end
            3'd2: begin quo = num_q / NUM_W'(3);  rem = num_q % NUM_W'(3);  end
            3'd3: begin quo = num_q / NUM_W'(5);  rem = num_q % NUM_W'(5);  end
            3'd4: begin quo = num_q / NUM_W'(7);  rem = num_q % NUM_W'(7);  end
            3'd5: begin quo = num_q / NUM_W'(11); rem = num_q % NUM_W'(11); end
            3'd6: begin quo = num_q / NUM_W'(13); rem = num_q % NUM_W'(13); end
            3'd7: begin quo = num_q / NUM_W'(17); rem = num_q % NUM_W'(17); end
            default: begin quo = num_q; rem = '0; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        lives_d = lives_q;
        qidx_d  = qidx_q;
        psel_d  = (sel_s != 3'd0) ? sel_s : psel_q;
        if (!ready_s) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_WAIT;
        end else if (clr_edge && state_q != ST_WAIT) begin
            state_d = ST_WAIT;
        end else if (que_edge) begin
            num_d   = NUM_W'(QUESTION_ROM[qidx_q]);
            qidx_d  = (qidx_q == QW'(NUM_Q - 1)) ? '0 : qidx_q + QW'(1);
            lives_d = {1'b0, HP} + 3'd1;
            psel_d  = '0;
            state_d = ST_PLAY;
        end else if (dec_edge && state_q == ST_PLAY && psel_q != 3'd0) begin
            if (rem == '0) begin
                num_d = quo;
                if (quo == NUM_W'(1)) state_d = ST_SOLVED;
            end else begin
                lives_d = lives_q - 3'd1;
                if (lives_q == 3'd1) state_d = ST_OVER;
            end
        end
    end

    // Display is built from next-state values so it lands in the same cycle as the update.
    logic [11:0]     bcd_num, bcd_p;
    logic            show;
    logic [5:0][3:0] dig;
    logic [5:0]      blk;
    logic [5:0][6:0] seg_w;

    always_comb begin
        bcd_num = bin2bcd(10'(num_d));
        bcd_p   = bin2bcd(10'(PRIME_LUT[psel_d]));
        show    = (state_d == ST_PLAY) || (state_d == ST_SOLVED) || (state_d == ST_OVER);
        dig[0]  = bcd_num[3:0];
        blk[0]  = !show;
        dig[1]  = bcd_num[7:4];
        blk[1]  = !show || (bcd_num[11:4] == 8'd0);
        dig[2]  = bcd_num[11:8];
        blk[2]  = !show || (bcd_num[11:8] == 4'd0);
        dig[3]  = bcd_p[3:0];
        blk[3]  = !show || (psel_d == 3'd0);
        dig[4]  = bcd_p[7:4];
        blk[4]  = !show || (bcd_p[11:4] == 8'd0);
        dig[5]  = {1'b0, lives_d};
        blk[5]  = !show;
        hex_d   = seg_w;
        if (state_d == ST_WAIT) hex_d[0] = SEG_DASH;
        LEDR    = (state_q == ST_SOLVED);
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        seg7_dec u_seg (
            .digit_i (dig[g]),
            .blank_i (blk[g]),
            .seg_o   (seg_w[g])
        );
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_factor_quiz_top.sv
// Bench for factor_quiz_top: directed game walk-through followed by random play against a game-level model.
module tb_factor_quiz_top;

    logic       clk, rst, dec, clr, ready, que;
    logic [1:0] hp;
    logic [2:0] sel;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       ledr;

    int n_tests = 0;
    int n_fail  = 0;

    factor_quiz_top #(.NUM_Q(8), .NUM_W(10)) dut (
        .CLK(clk), .RST(rst), .HP(hp), .SEL(sel), .DEC(dec), .CLR(clr),
        .READY(ready), .QUE(que),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .LEDR(ledr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int primes [8] = '{0, 2, 3, 5, 7, 11, 13, 17};
    int rom    [8] = '{12, 30, 84, 90, 210, 360, 462, 884};

    string m_mode;
    int    m_num, m_lives, m_p, m_qidx;
    bit    pd, pc, pq;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic model_update();
        bit de, ce, qe;
        int newp;
        if (rst) begin
            m_mode = "IDLE"; m_num = 0; m_lives = 0; m_p = 0; m_qidx = 0;
            pd = 0; pc = 0; pq = 0;
            return;
        end
        de = dec && !pd;
        ce = clr && !pc;
        qe = que && !pq;
        newp = (sel != 3'd0) ? primes[sel] : m_p;
        if (!ready) begin
            m_mode = "IDLE";
        end else if (m_mode == "IDLE") begin
            m_mode = "WAIT";
        end else if (ce && m_mode != "WAIT") begin
            m_mode = "WAIT";
        end else if (qe) begin
            m_num   = rom[m_qidx];
            m_qidx  = (m_qidx + 1) % 8;
            m_lives = int'(hp) + 1;
            newp    = 0;
            m_mode  = "PLAY";
        end else if (de && m_mode == "PLAY" && m_p != 0) begin
            if (m_num % m_p == 0) begin
                m_num = m_num / m_p;
                if (m_num == 1) m_mode = "SOLVED";
            end else begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = "OVER";
            end
        end
        m_p = newp;
        pd = dec; pc = clr; pq = que;
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [6:0] e   [6];
        logic [6:0] act [6];
        act[0] = hex0; act[1] = hex1; act[2] = hex2;
        act[3] = hex3; act[4] = hex4; act[5] = hex5;
        for (int i = 0; i < 6; i++) e[i] = 7'h7F;
        if (m_mode == "WAIT") begin
            e[0] = 7'h3F;
        end else if (m_mode != "IDLE") begin
            e[0] = seg_of(m_num % 10);
            if (m_num >= 10)  e[1] = seg_of((m_num / 10) % 10);
            if (m_num >= 100) e[2] = seg_of(m_num / 100);
            if (m_p != 0)     e[3] = seg_of(m_p % 10);
            if (m_p >= 10)    e[4] = seg_of(m_p / 10);
            e[5] = seg_of(m_lives);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("HEX%0d", i), act[i], e[i]);
        chk("LEDR", {6'd0, ledr}, {6'd0, (m_mode == "SOLVED")});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic apply_prime(input logic [2:0] code);
        sel = code; cycle();
        sel = 3'd0; dec = 1'b1; cycle();
        dec = 1'b0; cycle();
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; dec = 1'b0; clr = 1'b0; que = 1'b0; hp = 2'd0; sel = 3'd0;
        cycle(); cycle();
        chk("reset_hex0", hex0, 7'h7F);
        chk("reset_ledr", {6'd0, ledr}, 7'd0);

        rst = 1'b0; ready = 1'b1; cycle();
        chk("wait_dash", hex0, 7'h3F);
        chk("wait_hex1", hex1, 7'h7F);

        hp = 2'd0; que = 1'b1; cycle(); que = 1'b0;
        chk("q12_hex0", hex0, 7'h24);
        chk("q12_hex1", hex1, 7'h79);
        chk("q12_hex2", hex2, 7'h7F);
        chk("q12_hex5", hex5, 7'h79);

        sel = 3'd1; cycle(); cycle(); sel = 3'd0; cycle();
        dec = 1'b1; cycle(); dec = 1'b0;
        chk("div2_hex0", hex0, 7'h02);
        chk("div2_hex3", hex3, 7'h24);
        chk("div2_lives", hex5, 7'h79);

        cycle(); sel = 3'd3; cycle(); sel = 3'd0; dec = 1'b1; cycle(); dec = 1'b0;
        chk("wrong5_lives0", hex5, 7'h40);
        chk("wrong5_num6", hex0, 7'h02);
        cycle(); dec = 1'b1; cycle(); dec = 1'b0;
        chk("over_dec_ignored", hex0, 7'h02);

        hp = 2'd3; que = 1'b1; cycle(); que = 1'b0;
        chk("q30_hex1", hex1, 7'h30);
        chk("q30_hex0", hex0, 7'h40);
        apply_prime(3'd1); apply_prime(3'd2); apply_prime(3'd3);
        chk("solved_ledr", {6'd0, ledr}, 7'd1);
        chk("solved_hex0", hex0, 7'h79);
        chk("solved_lives", hex5, 7'h19);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("clr_ledr", {6'd0, ledr}, 7'd0);
        chk("clr_dash", hex0, 7'h3F);

        que = 1'b1; cycle(); que = 1'b0; cycle();
        ready = 1'b0; cycle();
        chk("idle_hex0", hex0, 7'h7F);
        chk("idle_hex5", hex5, 7'h7F);
        sel = 3'd1; cycle(); sel = 3'd0; dec = 1'b1; cycle(); dec = 1'b0; cycle();
        ready = 1'b1; cycle(); cycle();
        rst = 1'b1; dec = 1'b1; cycle(); cycle();
        chk("rst_dec_hex0", hex0, 7'h7F);
        rst = 1'b0; cycle(); dec = 1'b0; cycle();

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            ready = ($urandom_range(0, 39) != 0);
            dec   = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 29) == 0);
            que   = ($urandom_range(0, 11) == 0);
            hp    = 2'($urandom);
            sel   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            if (que) sel = 3'd0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
